// File: rtl/haar_pkg.sv
// Shared types and constants for the Haar feature address generator.
package haar_pkg;

  localparam int HAAR_COORD_W  = 5;
  localparam int HAAR_WEIGHT_W = 4;

  // One rectangle of a feature descriptor; x sits in the LSBs.
  typedef struct packed {
    logic [HAAR_WEIGHT_W-1:0] weight;
    logic [HAAR_COORD_W-1:0]  h;
    logic [HAAR_COORD_W-1:0]  w;
    logic [HAAR_COORD_W-1:0]  y;
    logic [HAAR_COORD_W-1:0]  x;
  } rect_t;

  // Corner order within a rectangle: (x,y) (x+w,y) (x,y+h) (x+w,y+h).
  localparam logic [1:0] PT_A = 2'd0;
  localparam logic [1:0] PT_B = 2'd1;
  localparam logic [1:0] PT_C = 2'd2;
  localparam logic [1:0] PT_D = 2'd3;

  // Bit n is the accumulate sign of corner n: 1 = add, 0 = subtract.
  localparam logic [3:0] PT_SIGN = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  function automatic logic pt_sign(input logic [1:0] pt);
    return PT_SIGN[pt];
  endfunction

endpackage

// File: rtl/haar_point_addr.sv
// Corner point -> integral-image word address: (win_y+py)*LINE_W + (win_x+px).
// Arithmetic runs at the natural full width and is truncated to ADDR_WIDTH.
module haar_point_addr #(
  parameter int ADDR_WIDTH  = 30,
  parameter int LINE_W      = 21,
  parameter int WIN_COORD_W = 10,
  parameter int PT_W        = 6
) (
  input  logic [WIN_COORD_W-1:0] win_x_i,
  input  logic [WIN_COORD_W-1:0] win_y_i,
  input  logic [PT_W-1:0]        px_i,
  input  logic [PT_W-1:0]        py_i,
  output logic [ADDR_WIDTH-1:0]  addr_o
);

  localparam int SUM_W  = ((WIN_COORD_W > PT_W) ? WIN_COORD_W : PT_W) + 1;
  localparam int NAT_W  = SUM_W + $clog2(LINE_W + 1) + 1;
  localparam int FULL_W = (NAT_W > ADDR_WIDTH) ? NAT_W : ADDR_WIDTH;

  logic [FULL_W-1:0] row, col, full;

  // Row/column sums, then one multiply-add by the line length.
  always_comb begin
    row  = FULL_W'(win_y_i) + FULL_W'(py_i);
    col  = FULL_W'(win_x_i) + FULL_W'(px_i);
    full = row * FULL_W'(LINE_W) + col;
  end

  assign addr_o = full[ADDR_WIDTH-1:0];

endmodule

// File: rtl/haar_addr_gen.sv
// Haar feature address generator: one descriptor of up to RECT_MAX
// rectangles in, four tagged integral-image corner addresses per rectangle
// out, one per valid/ready handshake.
// Optional feature macro: HAAR_BOUNDS_CHECK_EN (reject rectangles that leave
// the scan window; err_o pulses and nothing is emitted).
module haar_addr_gen
  import haar_pkg::*;
#(
  parameter int ADDR_WIDTH  = 30,
  parameter int LINE_W      = 21,
  parameter int WIN_SIZE    = 20,
  parameter int COORD_W     = HAAR_COORD_W,
  parameter int WIN_COORD_W = 10,
  parameter int WEIGHT_W    = HAAR_WEIGHT_W,
  parameter int RECT_MAX    = 3,
  localparam int CNT_W      = $clog2(RECT_MAX + 1),
  localparam int IDX_W      = (RECT_MAX > 1) ? $clog2(RECT_MAX) : 1,
  localparam int RECT_W     = 4 * COORD_W + WEIGHT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         desc_val_i,
  output logic                         desc_rdy_o,
  input  logic [CNT_W-1:0]             desc_cnt_i,
  input  logic [RECT_MAX*RECT_W-1:0]   desc_rects_i,
  input  logic [WIN_COORD_W-1:0]       win_x_i,
  input  logic [WIN_COORD_W-1:0]       win_y_i,
  output logic [ADDR_WIDTH-1:0]        addr_o,
  output logic                         addr_val_o,
  input  logic                         addr_rdy_i,
  output logic                         addr_sign_o,
  output logic [WEIGHT_W-1:0]          addr_weight_o,
  output logic [IDX_W-1:0]             addr_rect_o,
  output logic [1:0]                   addr_pt_o,
  output logic                         addr_last_o,
  output logic                         err_o,
  output logic                         busy_o
);

  // A window wider than an image line would alias neighbouring rows.
  if (WIN_SIZE >= LINE_W) begin : g_bad_geom
    $error("haar_addr_gen: WIN_SIZE must be smaller than LINE_W");
  end

  state_e                   state_q, state_d;
  logic                     rdy_q;
  rect_t [RECT_MAX-1:0]     rects_q;
  logic [WIN_COORD_W-1:0]   wx_q, wy_q;
  logic [CNT_W-1:0]         cnt_q, cnt_sat;
  logic [IDX_W-1:0]         rect_q, rect_n;
  logic [1:0]               pt_q, pt_n;
  logic [ADDR_WIDTH-1:0]    addr_q, pt_addr;
  logic [COORD_W:0]         px, py;
  logic                     desc_hs, emit, last, adv, viol, err;

  assign desc_hs = desc_val_i & rdy_q;
  assign emit    = (state_q == ST_EMIT);
  assign cnt_sat = (int'(cnt_q) > RECT_MAX) ? CNT_W'(RECT_MAX) : cnt_q;
  assign last    = (pt_q == PT_D) && (int'(rect_q) == int'(cnt_q) - 1);

`ifdef HAAR_BOUNDS_CHECK_EN
  // Flag any used rectangle whose far edge passes the window edge.
  always_comb begin
    viol = 1'b0;
    for (int i = 0; i < RECT_MAX; i++) begin
      if (i < int'(cnt_sat) &&
          ((int'(rects_q[i].x) + int'(rects_q[i].w) > WIN_SIZE) ||
           (int'(rects_q[i].y) + int'(rects_q[i].h) > WIN_SIZE)))
        viol = 1'b1;
    end
  end
`else
  assign viol = 1'b0;
`endif

  // Next-state and corner-walk control.
  always_comb begin
    state_d = state_q;
    rect_n  = rect_q;
    pt_n    = pt_q;
    adv     = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_IDLE: if (desc_hs) state_d = ST_LOAD;
      ST_LOAD: begin
        rect_n = '0;
        pt_n   = PT_A;
        if (cnt_sat == '0) begin
          state_d = ST_IDLE;
        end else if (viol) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          adv     = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: if (addr_rdy_i) begin
        if (last) begin
          state_d = ST_IDLE;
        end else begin
          adv = 1'b1;
          if (pt_q == PT_D) begin
            pt_n   = PT_A;
            rect_n = rect_q + IDX_W'(1);
          end else begin
            pt_n = pt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Corner mux: pick the point for the address about to be registered.
  always_comb begin
    px = {1'b0, rects_q[rect_n].x} + (pt_n[0] ? {1'b0, rects_q[rect_n].w} : '0);
    py = {1'b0, rects_q[rect_n].y} + (pt_n[1] ? {1'b0, rects_q[rect_n].h} : '0);
  end

  haar_point_addr #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .LINE_W      (LINE_W),
    .WIN_COORD_W (WIN_COORD_W),
    .PT_W        (COORD_W + 1)
  ) u_pt_addr (
    .win_x_i (wx_q),
    .win_y_i (wy_q),
    .px_i    (px),
    .py_i    (py),
    .addr_o  (pt_addr)
  );

  // State, descriptor capture and registered address/index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      rects_q <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      cnt_q   <= '0;
      rect_q  <= '0;
      pt_q    <= PT_A;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_IDLE);
      if (desc_hs) begin
        rects_q <= desc_rects_i;
        wx_q    <= win_x_i;
        wy_q    <= win_y_i;
        cnt_q   <= desc_cnt_i;
      end else if (state_q == ST_LOAD) begin
        cnt_q <= cnt_sat;
      end
      if (adv) begin
        rect_q <= rect_n;
        pt_q   <= pt_n;
        addr_q <= pt_addr;
      end
    end
  end

  assign desc_rdy_o    = rdy_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign err_o         = err;
  assign addr_val_o    = emit;
  assign addr_o        = emit ? addr_q : '0;
  assign addr_sign_o   = emit & pt_sign(pt_q);
  assign addr_weight_o = emit ? rects_q[rect_q].weight : '0;
  assign addr_rect_o   = emit ? rect_q : '0;
  assign addr_pt_o     = emit ? pt_q : '0;
  assign addr_last_o   = emit & last;

endmodule

// File: tb/tb_haar_addr_gen.sv
// Directed bench for haar_addr_gen with hand-computed address streams.
module tb_haar_addr_gen;
  import haar_pkg::*;

  logic        clk_i, rst_ni;
  logic        desc_val_i, desc_rdy_o;
  logic [1:0]  desc_cnt_i;
  logic [71:0] desc_rects_i;
  logic [9:0]  win_x_i, win_y_i;
  logic [29:0] addr_o;
  logic        addr_val_o, addr_rdy_i, addr_sign_o;
  logic [3:0]  addr_weight_o;
  logic [1:0]  addr_rect_o, addr_pt_o;
  logic        addr_last_o, err_o, busy_o;

  int checks = 0;
  int errors = 0;

  int ea[12], es[12], ew[12], er[12], ep[12], el[12];

  haar_addr_gen dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .desc_val_i(desc_val_i), .desc_rdy_o(desc_rdy_o),
    .desc_cnt_i(desc_cnt_i), .desc_rects_i(desc_rects_i),
    .win_x_i(win_x_i), .win_y_i(win_y_i),
    .addr_o(addr_o), .addr_val_o(addr_val_o), .addr_rdy_i(addr_rdy_i),
    .addr_sign_o(addr_sign_o), .addr_weight_o(addr_weight_o),
    .addr_rect_o(addr_rect_o), .addr_pt_o(addr_pt_o),
    .addr_last_o(addr_last_o), .err_o(err_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic rect_t mk(input int x, input int y, input int w, input int h, input int wt);
    rect_t r;
    r.x = 5'(x); r.y = 5'(y); r.w = 5'(w); r.h = 5'(h); r.weight = 4'(wt);
    return r;
  endfunction

  // Fill four expected entries for one rectangle (signs + - - +).
  task automatic set4(input int i0, input int rect, input int wt,
                      input int a0, input int a1, input int a2, input int a3, input int lastr);
    ea[i0] = a0; ea[i0+1] = a1; ea[i0+2] = a2; ea[i0+3] = a3;
    es[i0] = 1;  es[i0+1] = 0;  es[i0+2] = 0;  es[i0+3] = 1;
    for (int j = 0; j < 4; j++) begin
      ew[i0+j] = wt; er[i0+j] = rect; ep[i0+j] = j; el[i0+j] = 0;
    end
    el[i0+3] = lastr;
  endtask

  function automatic logic [63:0] all_outs();
    return {20'd0, desc_rdy_o, addr_val_o, addr_o, addr_sign_o, addr_weight_o,
            addr_rect_o, addr_pt_o, addr_last_o, err_o, busy_o};
  endfunction

  // Present one descriptor; returns #1 after its handshake edge.
  task automatic send(input int cnt, input rect_t [2:0] rs, input int wx, input int wy);
    desc_cnt_i   = 2'(cnt);
    desc_rects_i = rs;
    win_x_i      = 10'(wx);
    win_y_i      = 10'(wy);
    desc_val_i   = 1'b1;
    @(posedge clk_i); #1;
    desc_val_i   = 1'b0;
    desc_rects_i = '1;
    win_x_i      = '1;
    win_y_i      = '1;
    check("hs_busy", busy_o, 1);
    check("hs_rdy", desc_rdy_o, 0);
    check("hs_val", addr_val_o, 0);
  endtask

  // Consume n_stop of n_total expected addresses, stalling at index stall_at.
  task automatic stream(input int n_total, input int n_stop, input int stall_at, input int stall_len);
    int k = 0;
    int cyc = 0;
    int stalled = 0;
    bit seen = 0;
    addr_rdy_i = 1'b1;
    while (k < n_stop && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
      if (addr_val_o && !seen) begin
        seen = 1;
        check("first_valid_cyc", cyc, 1);
      end
      if (addr_val_o) begin
        if (k == stall_at && stalled < stall_len) begin
          addr_rdy_i = 1'b0;
          if (stalled > 0) begin
            check($sformatf("hold_addr%0d", k), addr_o, ea[k]);
            check($sformatf("hold_pt%0d", k), addr_pt_o, ep[k]);
          end
          stalled++;
        end else begin
          addr_rdy_i = 1'b1;
          check($sformatf("addr%0d", k), addr_o, ea[k]);
          check($sformatf("sign%0d", k), addr_sign_o, es[k]);
          check($sformatf("weight%0d", k), addr_weight_o, ew[k]);
          check($sformatf("rect%0d", k), addr_rect_o, er[k]);
          check($sformatf("pt%0d", k), addr_pt_o, ep[k]);
          check($sformatf("last%0d", k), addr_last_o, el[k]);
          k++;
        end
      end
    end
    check("handshakes", k, n_stop);
    addr_rdy_i = 1'b1;
    if (n_stop == n_total) begin
      check("emit_cycles", cyc, n_total + stall_len);
      @(posedge clk_i); #1;
      check("tail_val", addr_val_o, 0);
      check("tail_rdy", desc_rdy_o, 1);
      check("tail_busy", busy_o, 0);
    end
  endtask

  initial begin
    rect_t [2:0] rs;
    rst_ni = 1'b0; desc_val_i = 1'b0; addr_rdy_i = 1'b1;
    desc_cnt_i = '0; desc_rects_i = '0; win_x_i = '0; win_y_i = '0;

    // Reset state and first ready edge.
    #2;  check("rst_outs", all_outs(), 0);
    #20; rst_ni = 1'b1;
    #1;  check("rdy_before_edge", desc_rdy_o, 0);
    @(posedge clk_i); #1;
    check("rdy_after_edge", desc_rdy_o, 1);

    // Single rect, window (0,0).
    rs = '0; rs[0] = mk(2, 3, 4, 5, 2);
    set4(0, 0, 2, 65, 69, 170, 174, 1);
    send(1, rs, 0, 0);
    stream(4, 4, -1, 0);

    // Same descriptor with 3 stalled cycles on the first address.
    send(1, rs, 0, 0);
    stream(4, 4, 0, 3);

    // Window offset (10,1).
    rs = '0; rs[0] = mk(0, 0, 1, 1, 5);
    set4(0, 0, 5, 31, 32, 52, 53, 1);
    send(1, rs, 10, 1);
    stream(4, 4, -1, 0);

    // Three rects, weights -1/2/3.
    rs[0] = mk(0, 0, 1, 1, 15);
    rs[1] = mk(1, 1, 2, 2, 2);
    rs[2] = mk(5, 2, 3, 1, 3);
    set4(0, 0, 15, 0, 1, 21, 22, 0);
    set4(4, 1, 2, 22, 24, 64, 66, 0);
    set4(8, 2, 3, 47, 50, 68, 71, 1);
    send(3, rs, 0, 0);
    stream(12, 12, -1, 0);

    // Zero count: nothing emitted, ready returns.
    send(0, rs, 0, 0);
    check("cnt0_err", err_o, 0);
    @(posedge clk_i); #1;
    check("cnt0_val", addr_val_o, 0);
    check("cnt0_rdy", desc_rdy_o, 1);
    check("cnt0_busy", busy_o, 0);

    // Count 7 saturates to RECT_MAX.
    send(7, rs, 0, 0);
    stream(12, 12, -1, 0);

    // Rectangle past the window edge.
    rs = '0; rs[0] = mk(18, 0, 4, 2, 1);
`ifdef HAAR_BOUNDS_CHECK_EN
    send(1, rs, 0, 0);
    check("bnd_err_pulse", err_o, 1);
    @(posedge clk_i); #1;
    check("bnd_err_clear", err_o, 0);
    check("bnd_val", addr_val_o, 0);
    check("bnd_rdy", desc_rdy_o, 1);
`else
    set4(0, 0, 1, 18, 22, 60, 64, 1);
    send(1, rs, 0, 0);
    check("bnd_no_err", err_o, 0);
    stream(4, 4, -1, 0);
`endif

    // Reset after the fifth address, then a fresh descriptor.
    rs[0] = mk(0, 0, 1, 1, 15);
    rs[1] = mk(1, 1, 2, 2, 2);
    rs[2] = mk(5, 2, 3, 1, 3);
    set4(0, 0, 15, 0, 1, 21, 22, 0);
    set4(4, 1, 2, 22, 24, 64, 66, 0);
    set4(8, 2, 3, 47, 50, 68, 71, 1);
    send(3, rs, 0, 0);
    stream(12, 5, -1, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1; check("midrst_outs", all_outs(), 0);
    #2; rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("midrst_rdy", desc_rdy_o, 1);
    rs = '0; rs[0] = mk(2, 3, 4, 5, 2);
    set4(0, 0, 2, 65, 69, 170, 174, 1);
    send(1, rs, 0, 0);
    stream(4, 4, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
